// File: rtl/fpu_cvt_sched.sv
// fpu_cvt_sched: shares one combinational int-to-float converter between two
// requesters (port 0 = core FPU issue, port 1 = secondary vector/debug).
// The requesters are arbitrated round-robin. The rounding mode is resolved
// when a request is accepted, and the result leaves a two-stage registered
// pipeline.
//
// Ports:
//   clk_i, reset_i (async, active-low), flush_i (sync kill of in-flight ops)
//   frm_i          dynamic rounding mode, used when a request carries rm=3'b111
//   rX_valid_i / rX_ready_o                request handshake, X = 0/1
//   rX_a_i, rX_unsigned_i, rX_rm_i, rX_tag_i   request payload
//   resp_valid_o / resp_ready_i            result handshake
//   resp_data_o, resp_src_o, resp_tag_o, resp_illegal_o   result payload
//   busy_o         high while either pipeline stage holds an entry
module fpu_cvt_sched #(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [2:0]       frm_i,
    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [31:0]      r0_a_i,
    input  logic             r0_unsigned_i,
    input  logic [2:0]       r0_rm_i,
    input  logic [TAG_W-1:0] r0_tag_i,
    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [31:0]      r1_a_i,
    input  logic             r1_unsigned_i,
    input  logic [2:0]       r1_rm_i,
    input  logic [TAG_W-1:0] r1_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_data_o,
    output logic             resp_src_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_illegal_o,
    output logic             busy_o
);

    localparam int DATA_W = 32;

    function automatic logic [4:0] lead_one(input logic [DATA_W-1:0] v);
        logic [4:0] pos;
        pos = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (v[i]) pos = i[4:0];
        end
        return pos;
    endfunction

    // Round-increment decision from lsb / guard / sticky for each IEEE mode.
    function automatic logic round_up(input logic [2:0] rm, input logic neg,
                                      input logic lsb, input logic grd, input logic stk);
        logic up;
        case (rm)
            3'b000:  up = grd & (stk | lsb);   // nearest, ties to even
            3'b010:  up = neg & (grd | stk);   // toward -inf
            3'b011:  up = ~neg & (grd | stk);  // toward +inf
            3'b100:  up = grd;                 // nearest, ties away
            default: up = 1'b0;                // toward zero
        endcase
        return up;
    endfunction

    function automatic logic [31:0] fpu_cvt_to_float(input logic signed [DATA_W-1:0] a,
                                                     input logic uns, input logic [2:0] rm);
        logic              neg;
        logic [DATA_W-1:0] mag;
        logic [DATA_W-1:0] norm;
        logic [4:0]        pos;
        logic [24:0]       mant;
        logic [7:0]        expo;
        logic [22:0]       frac;
        neg  = ~uns & a[DATA_W-1];
        // -(-2^31) wraps back to 32'h80000000, which read unsigned is the right magnitude.
        mag  = neg ? DATA_W'(-a) : DATA_W'(a);
        pos  = lead_one(mag);
        norm = mag << (5'd31 - pos);
        mant = {1'b0, norm[31:8]}
             + {24'd0, round_up(rm, neg, norm[8], norm[7], |norm[6:0])};
        // A mantissa carry-out means the value rounded up to the next power of two.
        expo = 8'd127 + {3'd0, pos} + {7'd0, mant[24]};
        frac = mant[24] ? mant[23:1] : mant[22:0];
        return (mag == '0) ? 32'h0 : {neg, expo, frac};
    endfunction

    logic                     last;
    logic                     vld_p1, vld_p2;
    logic signed [DATA_W-1:0] a_p1;
    logic                     uns_p1, src_p1, ill_p1;
    logic [2:0]               rm_p1;
    logic [TAG_W-1:0]         tag_p1;

    logic       grant0, grant1, s2_adv, s1_can, accept, sel;
    logic [2:0] rm_req, rm_res;

    // Arbitration looks only at the valids; on a tie, the port not served last wins.
    assign grant0 = r0_valid_i & (~r1_valid_i | last);
    assign grant1 = r1_valid_i & (~r0_valid_i | ~last);
    assign s2_adv = vld_p1 & (~vld_p2 | resp_ready_i);
    assign s1_can = ~vld_p1 | s2_adv;

    // Held low during reset so that no requester sees a handshake the flops ignore.
    assign r0_ready_o = grant0 & s1_can & ~flush_i & reset_i;
    assign r1_ready_o = grant1 & s1_can & ~flush_i & reset_i;
    assign accept     = r0_ready_o | r1_ready_o;
    assign sel        = r1_ready_o;

    assign rm_req = sel ? r1_rm_i : r0_rm_i;
    assign rm_res = (rm_req == 3'b111) ? frm_i : rm_req;

    assign resp_valid_o = vld_p2;
    assign busy_o       = vld_p1 | vld_p2;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            last   <= 1'b1;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept ? 1'b1 : (s2_adv ? 1'b0 : vld_p1);
            vld_p2 <= s2_adv ? 1'b1 : ((vld_p2 & resp_ready_i) ? 1'b0 : vld_p2);
            if (accept) last <= sel;
        end
    end

    // ---- S1: operand register, loaded on accept ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_p1   <= sel ? r1_a_i : r0_a_i;
            uns_p1 <= sel ? r1_unsigned_i : r0_unsigned_i;
            tag_p1 <= sel ? r1_tag_i : r0_tag_i;
            src_p1 <= sel;
            rm_p1  <= rm_res;
            ill_p1 <= rm_res[2] & (rm_res[1] | rm_res[0]);
        end
    end

    // ---- S2: result register, drives the response outputs directly ----
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            resp_data_o    <= '0;
            resp_src_o     <= 1'b0;
            resp_tag_o     <= '0;
            resp_illegal_o <= 1'b0;
        end else if (s2_adv && !flush_i) begin
            resp_data_o    <= ill_p1 ? 32'h0 : fpu_cvt_to_float(a_p1, uns_p1, rm_p1);
            resp_src_o     <= src_p1;
            resp_tag_o     <= tag_p1;
            resp_illegal_o <= ill_p1;
        end
    end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
module tb_fpu_cvt_sched;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       frm = 3'b000;
    logic             r0_valid = 1'b0, r1_valid = 1'b0;
    logic             r0_ready, r1_ready;
    logic [31:0]      r0_a = '0, r1_a = '0;
    logic             r0_uns = 1'b0, r1_uns = 1'b0;
    logic [2:0]       r0_rm = '0, r1_rm = '0;
    logic [TAG_W-1:0] r0_tag = '0, r1_tag = '0;
    logic             resp_valid, resp_src, resp_ill, busy;
    logic             resp_ready = 1'b1;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    always #5 clk = ~clk;

    fpu_cvt_sched #(.TAG_W(TAG_W)) dut (
        .clk_i(clk), .reset_i(reset_n), .flush_i(flush), .frm_i(frm),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_a_i(r0_a),
        .r0_unsigned_i(r0_uns), .r0_rm_i(r0_rm), .r0_tag_i(r0_tag),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_a_i(r1_a),
        .r1_unsigned_i(r1_uns), .r1_rm_i(r1_rm), .r1_tag_i(r1_tag),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_src_o(resp_src), .resp_tag_o(resp_tag),
        .resp_illegal_o(resp_ill), .busy_o(busy)
    );

    typedef struct {
        logic [31:0]      data;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               age;
    } ent_t;

    ent_t q[$];
    bit   m_last = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   gq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion: exact value, then round by comparing the discarded
    // remainder against half an ulp.
    function automatic logic [31:0] ref_cvt(input logic [31:0] a, input logic uns, input logic [2:0] rm);
        longint unsigned mag, qm, rem, half;
        int              p, k;
        bit              sign, up;
        logic [7:0]      e;
        logic [31:0]     r;
        sign = !uns && a[31];
        mag  = sign ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        up   = 1'b0;
        if (rm >= 3'd5 || mag == 0) begin
            r = 32'h0;
        end else begin
            p = 0;
            while ((mag >> (p + 1)) != 0) p++;
            if (p <= 23) begin
                e = 8'(127 + p);
                r = {sign, e, 23'((mag << (23 - p)) & 64'h7FFFFF)};
            end else begin
                k    = p - 23;
                qm   = mag >> k;
                rem  = mag - (qm << k);
                half = 64'd1 << (k - 1);
                case (rm)
                    3'd0:    up = (rem > half) || (rem == half && qm[0]);
                    3'd2:    up = sign && rem != 0;
                    3'd3:    up = !sign && rem != 0;
                    3'd4:    up = rem >= half;
                    default: up = 1'b0;
                endcase
                qm = qm + 64'(up);
                if (qm == (64'd1 << 24)) begin
                    qm = qm >> 1;
                    k++;
                end
                e = 8'(150 + k);
                r = {sign, e, qm[22:0]};
            end
        end
        return r;
    endfunction

    // The pipeline behaves as a two-entry queue: a result becomes visible one
    // edge after it was accepted, and a slot freed by a pop is reusable in the same cycle.
    function automatic void exp_ready(output bit e0, output bit e1);
        bit pop, can, g0, g1;
        pop = q.size() > 0 && q[0].age >= 1 && resp_ready;
        can = (q.size() - int'(pop)) < 2;
        g0  = r0_valid && (!r1_valid || m_last);
        g1  = r1_valid && (!r0_valid || !m_last);
        e0  = reset_n && !flush && can && g0;
        e1  = reset_n && !flush && can && g1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit          e0, e1, pop;
        ent_t        ent;
        logic [31:0] a;
        logic [2:0]  rm;
        logic        uns;
        if (!reset_n) begin
            q.delete();
            m_last = 1'b1;
        end else begin
            exp_ready(e0, e1);
            pop = q.size() > 0 && q[0].age >= 1 && resp_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (e0 || e1) begin
                    a       = e1 ? r1_a : r0_a;
                    uns     = e1 ? r1_uns : r0_uns;
                    rm      = e1 ? r1_rm : r0_rm;
                    rm      = (rm == 3'b111) ? frm : rm;
                    ent.ill = rm >= 3'd5;
                    ent.data = ref_cvt(a, uns, rm);
                    ent.src = e1;
                    ent.tag = e1 ? r1_tag : r0_tag;
                    ent.age = 0;
                    q.push_back(ent);
                    m_last = e1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e0, e1, ev;
        exp_ready(e0, e1);
        ev = q.size() > 0 && q[0].age >= 1;
        chk("r0_ready", 32'(r0_ready), 32'(e0));
        chk("r1_ready", 32'(r1_ready), 32'(e1));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (ev) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_src", 32'(resp_src), 32'(q[0].src));
            chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
            chk("resp_illegal", 32'(resp_ill), 32'(q[0].ill));
        end else if (!reset_n) begin
            chk("rst_data", resp_data, 32'h0);
            chk("rst_tag", 32'(resp_tag), 32'h0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int port, input logic [31:0] a, input logic uns,
                        input logic [2:0] rm, input logic [TAG_W-1:0] tag);
        bit done;
        done = 1'b0;
        if (port == 0) begin
            r0_valid = 1'b1; r0_a = a; r0_uns = uns; r0_rm = rm; r0_tag = tag;
        end else begin
            r1_valid = 1'b1; r1_a = a; r1_uns = uns; r1_rm = rm; r1_tag = tag;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (port == 0 ? r0_ready : r1_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: port %0d got no ready expected ready within 20 cycles", port);
        end
    endtask

    task automatic set_ops(input int port, input int n);
        logic [31:0]      a;
        logic [2:0]       rm;
        logic [TAG_W-1:0] tag;
        a   = 32'h0123_4567 * 32'(n + 1) ^ (port == 1 ? 32'hA5A5_0000 : 32'h0);
        rm  = (n % 6 == 5) ? 3'b111 : 3'(n % 5);
        tag = 5'(port * 16 + n);
        if (port == 0) begin
            r0_a = a; r0_uns = n[0]; r0_rm = rm; r0_tag = tag;
        end else begin
            r1_a = a; r1_uns = n[0]; r1_rm = rm; r1_tag = tag;
        end
    endtask

    task automatic run_both(input int ncyc, input int st, input int sl);
        int n0, n1;
        bit a0, a1;
        n0 = 0;
        n1 = 0;
        set_ops(0, n0);
        set_ops(1, n1);
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            resp_ready = !(c >= st && c < st + sl);
            @(negedge clk);
            a0 = r0_ready;
            a1 = r1_ready;
            if (a0) gq.push_back(0);
            if (a1) gq.push_back(1);
            if (sl > 0 && c == st + 2) begin
                chk("stall_r0_ready", 32'(r0_ready), 32'h0);
                chk("stall_r1_ready", 32'(r1_ready), 32'h0);
            end
            @(posedge clk);
            #1;
            if (a0) begin n0++; set_ops(0, n0); end
            if (a1) begin n1++; set_ops(1, n1); end
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        resp_ready = 1'b1;
        idle(4);
    endtask

    typedef struct {
        int               port;
        logic [31:0]      a;
        logic             uns;
        logic [2:0]       rm;
        logic [2:0]       frm;
        logic [TAG_W-1:0] tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        // Hand-computed values that pin the reference conversion.
        chk("ref_one", ref_cvt(32'h1, 1'b0, 3'd0), 32'h3F800000);
        chk("ref_neg1", ref_cvt(32'hFFFFFFFF, 1'b0, 3'd0), 32'hBF800000);
        chk("ref_u_max", ref_cvt(32'hFFFFFFFF, 1'b1, 3'd0), 32'h4F800000);
        chk("ref_zero", ref_cvt(32'h0, 1'b0, 3'd0), 32'h00000000);
        chk("ref_rne_tie", ref_cvt(32'h01000001, 1'b0, 3'd0), 32'h4B800000);
        chk("ref_rup", ref_cvt(32'h01000001, 1'b0, 3'd3), 32'h4B800001);
        chk("ref_rne_odd", ref_cvt(32'h01000003, 1'b0, 3'd0), 32'h4B800002);
        chk("ref_minint", ref_cvt(32'h80000000, 1'b0, 3'd1), 32'hCF000000);
        chk("ref_illegal", ref_cvt(32'h01000001, 1'b0, 3'd5), 32'h0);

        // Reset state.
        #12;
        chk("reset_valid", 32'(resp_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_data", resp_data, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);

        // Single request: latency and payload.
        send(0, 32'h1, 1'b0, 3'b000, 5'd3);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(resp_valid), 32'h1);
        chk("lat_data", resp_data, 32'h3F800000);
        chk("lat_src", 32'(resp_src), 32'h0);
        chk("lat_tag", 32'(resp_tag), 32'd3);
        chk("lat_illegal", 32'(resp_ill), 32'h0);
        idle(2);

        // Directed conversion and rounding-mode vectors.
        vecs.push_back('{0, 32'hFFFFFFFF, 1'b0, 3'b000, 3'b000, 5'd1});
        vecs.push_back('{1, 32'hFFFFFFFF, 1'b1, 3'b000, 3'b000, 5'd2});
        vecs.push_back('{0, 32'h00000000, 1'b0, 3'b000, 3'b000, 5'd3});
        vecs.push_back('{1, 32'h01000001, 1'b0, 3'b000, 3'b000, 5'd4});
        vecs.push_back('{0, 32'h01000001, 1'b0, 3'b011, 3'b000, 5'd5});
        vecs.push_back('{1, 32'h01000001, 1'b0, 3'b111, 3'b011, 5'd6});
        vecs.push_back('{0, 32'h01000001, 1'b0, 3'b101, 3'b000, 5'd7});
        vecs.push_back('{1, 32'h01000001, 1'b0, 3'b111, 3'b110, 5'd8});
        vecs.push_back('{0, 32'h80000000, 1'b0, 3'b001, 3'b000, 5'd9});
        vecs.push_back('{1, 32'h00FFFFFF, 1'b0, 3'b100, 3'b000, 5'd10});
        vecs.push_back('{0, 32'h7FFFFFFF, 1'b0, 3'b010, 3'b000, 5'd11});
        vecs.push_back('{1, 32'h80000001, 1'b0, 3'b010, 3'b000, 5'd12});
        vecs.push_back('{0, 32'h01000003, 1'b0, 3'b000, 3'b000, 5'd13});
        foreach (vecs[i]) begin
            frm = vecs[i].frm;
            send(vecs[i].port, vecs[i].a, vecs[i].uns, vecs[i].rm, vecs[i].tag);
        end
        idle(4);

        // Both ports streaming from reset: grants alternate starting with port 0.
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        frm = 3'b001;
        gq.delete();
        run_both(12, 0, 0);
        chk("grant_0", 32'(gq.size() > 0 ? gq[0] : -1), 32'h0);
        chk("grant_1", 32'(gq.size() > 1 ? gq[1] : -1), 32'h1);
        chk("grant_2", 32'(gq.size() > 2 ? gq[2] : -1), 32'h0);

        // Backpressure from empty, then in the middle of a stream.
        run_both(14, 0, 5);
        run_both(16, 6, 5);

        // Flush with both stages full.
        resp_ready = 1'b0;
        send(0, 32'h0000_1234, 1'b0, 3'b000, 5'd20);
        send(1, 32'h0000_5678, 1'b1, 3'b000, 5'd21);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", 32'(resp_valid), 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        resp_ready = 1'b1;
        idle(3);

        // Asynchronous reset with entries in flight.
        resp_ready = 1'b0;
        send(1, 32'h0000_00FF, 1'b0, 3'b000, 5'd9);
        send(0, 32'h0000_0042, 1'b0, 3'b000, 5'd10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(resp_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_data", resp_data, 32'h0);
        chk("arst_src", 32'(resp_src), 32'h0);
        chk("arst_tag", 32'(resp_tag), 32'h0);
        chk("arst_illegal", 32'(resp_ill), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
